// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming RV32I instruction encoder. Takes decoded instruction fields,
//   packs them into the 32-bit R/I/S/B/U/J layouts, and emits each word with
//   a target word address. Two-stage valid/ready pipeline:
//     stage A : raw fields, loaded on the input handshake
//     stage B : encoded word + error flag, loaded from A through the packer
//   The address counter advances by 4 on every output handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous flush (drops in-flight words, reloads addr)
//   in_valid / in_ready   input handshake
//   in_fmt                0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
//   in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm
//                         instruction fields (imm is a signed byte offset,
//                         or the full upper value for U)
//   out_valid / out_ready output handshake
//   out_instr             encoded word
//   out_addr              word address of out_instr
//   out_err               immediate does not fit the format, or illegal fmt
module instr_encoder #(
    parameter int ADDR_W    = 32,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [31:0]       NOP  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } fields_t;

    // Stage A
    logic    a_valid_q, a_valid_d;
    fields_t a_q, a_d;
    // Stage B
    logic        b_valid_q, b_valid_d;
    logic [31:0] b_instr_q, b_instr_d;
    logic        b_err_q, b_err_d;
    // Address counter
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic        in_fire, out_fire, a_adv;
    logic [31:0] enc_instr;
    logic        enc_err;
    fields_t     in_f;

    assign in_f = '{fmt: in_fmt, opcode: in_opcode, funct3: in_funct3,
                    funct7: in_funct7, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    imm: in_imm};

    // A may accept when it is empty or when its word moves into B this cycle.
    assign in_ready = !a_valid_q || !b_valid_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = b_valid_q && out_ready;
    assign a_adv    = a_valid_q && (!b_valid_q || out_ready);

    // Packer. Fields are always packed from the truncated immediate; the
    // error flag only reports that the truncation lost information.
    always_comb begin
        enc_instr = NOP;
        enc_err   = 1'b0;
        unique case (a_q.fmt)
            FMT_R: enc_instr = {a_q.funct7, a_q.rs2, a_q.rs1, a_q.funct3,
                                a_q.rd, a_q.opcode};
            FMT_I: begin
                enc_instr = {a_q.imm[11:0], a_q.rs1, a_q.funct3, a_q.rd,
                             a_q.opcode};
                // bits 31:11 must all equal the sign bit of the 12-bit field
                enc_err   = !(&a_q.imm[31:11] || !(|a_q.imm[31:11]));
            end
            FMT_S: begin
                enc_instr = {a_q.imm[11:5], a_q.rs2, a_q.rs1, a_q.funct3,
                             a_q.imm[4:0], a_q.opcode};
                enc_err   = !(&a_q.imm[31:11] || !(|a_q.imm[31:11]));
            end
            FMT_B: begin
                enc_instr = {a_q.imm[12], a_q.imm[10:5], a_q.rs2, a_q.rs1,
                             a_q.funct3, a_q.imm[4:1], a_q.imm[11],
                             a_q.opcode};
                enc_err   = !(&a_q.imm[31:12] || !(|a_q.imm[31:12]))
                            || a_q.imm[0];
            end
            FMT_U: begin
                enc_instr = {a_q.imm[31:12], a_q.rd, a_q.opcode};
                enc_err   = |a_q.imm[11:0];
            end
            FMT_J: begin
                enc_instr = {a_q.imm[20], a_q.imm[10:1], a_q.imm[11],
                             a_q.imm[19:12], a_q.rd, a_q.opcode};
                enc_err   = !(&a_q.imm[31:20] || !(|a_q.imm[31:20]))
                            || a_q.imm[0];
            end
            default: begin
                enc_instr = NOP;
                enc_err   = 1'b1;
            end
        endcase
    end

    always_comb begin
        a_valid_d = a_valid_q;
        a_d       = a_q;
        b_valid_d = b_valid_q;
        b_instr_d = b_instr_q;
        b_err_d   = b_err_q;
        addr_d    = addr_q;

        if (a_adv) a_valid_d = 1'b0;
        if (in_fire) begin
            a_valid_d = 1'b1;
            a_d       = in_f;
        end

        if (out_fire) begin
            b_valid_d = 1'b0;
            addr_d    = addr_q + STEP;
        end
        if (a_adv) begin
            b_valid_d = 1'b1;
            b_instr_d = enc_instr;
            b_err_d   = enc_err;
        end

        // Flush wins over both handshakes; data registers may keep stale
        // contents since the valids gate them.
        if (clr) begin
            a_valid_d = 1'b0;
            b_valid_d = 1'b0;
            addr_d    = BASE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_q       <= '0;
            b_valid_q <= 1'b0;
            b_instr_q <= '0;
            b_err_q   <= 1'b0;
            addr_q    <= BASE;
        end else begin
            a_valid_q <= a_valid_d;
            a_q       <= a_d;
            b_valid_q <= b_valid_d;
            b_instr_q <= b_instr_d;
            b_err_q   <= b_err_d;
            addr_q    <= addr_d;
        end
    end

    assign out_valid = b_valid_q;
    assign out_instr = b_instr_q;
    assign out_err   = b_err_q;
    assign out_addr  = addr_q;

endmodule
